cipher_uart_tx: RTL and testbench
=================================

Name: cipher_uart_tx

Overview:
Downstream stage of the stream cipher. Takes 8-bit encrypted bytes over a valid/ready handshake and buffers them in a small FIFO. Transmits each byte as an asynchronous serial frame (start, 8 data bits LSB first, optional parity, stop) on a single line. It decouples cipher throughput from the slower serial link.

Parameters:
CLKS_PER_BIT, 4, clk cycles per serial bit period; legal range ≥2
FIFO_DEPTH, 4, byte entries in input FIFO; power of 2, ≥2

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
in_valid  input  1  upstream has a byte on in_data
in_data  input  8  encrypted byte from cipher stage
in_ready  output  1  FIFO can accept a byte this cycle
tx_serial  output  1  serial line, idle high
tx_busy  output  1  FSM not in IDLE
fifo_level  output  $clog2(FIFO_DEPTH+1)  bytes currently buffered
frames_sent  output  16  count of completed frames, wraps at 0xFFFF->0

Behaviour:
- Reset (async, active-high) values: tx_serial=1, tx_busy=0, fifo_level=0, in_ready=1, frames_sent=0, FSM=IDLE, FIFO pointers=0. Any in-flight frame is aborted and the line returns high immediately.
- Push: a byte is stored at the rising edge where in_valid && in_ready.
- in_ready = (fifo_level < FIFO_DEPTH). It is combinational from registered level only, with no pass-through.
- When full, in_ready=0 even if a pop occurs in the same cycle.
- Pop occurs only in IDLE when fifo_level>0. A simultaneous push and pop leaves the level unchanged.
- FIFO ordering is strictly first-in first-out. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
  - IDLE: tx_serial=1. If fifo_level>0 at an edge, pop the head into an 8-bit shift register, clear the bit-timer, and go to START.
  - START: tx_serial=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx_serial=shift[0], held CLKS_PER_BIT cycles per bit, shift right after each bit. After bit 7, go to PARITY (if enabled) or STOP.
  - STOP: tx_serial=1 for CLKS_PER_BIT cycles. On the final cycle, frames_sent increments and the FSM goes to IDLE.
- IDLE always lasts ≥1 cycle between frames. Inter-frame gap is one clk of idle high beyond the stop bit.
- Latency: a byte pushed at edge E into an empty FIFO with FSM in IDLE gives a start bit driven from edge E+1. fifo_level shows 1 for exactly one cycle.
- Frame length is 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT with parity. tx_busy=1 for the whole frame.
- Bit-timer counts 0..CLKS_PER_BIT-1. The state/bit advances on the edge where the timer equals CLKS_PER_BIT-1.
- in_data is ignored when in_valid=0. Input values are not checked.

Optional Feature:
- Macro: CIPHER_TX_PARITY_EN.
- Defined: PARITY state is inserted after DATA. tx_serial = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles, then STOP.
- Undefined: no PARITY state, and DATA goes directly to STOP. Frame length is 10*CLKS_PER_BIT.

Test Plan:
- Reset, then push 0xA5 once with CLKS_PER_BIT=4. Required response: from the next edge, tx_serial = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. tx_busy high 40 cycles, then frames_sent=1.
- Push 0x01, 0x02, 0x03, 0x04, 0x05, 0x06 back-to-back with in_valid held high. Required response: in_ready drops when fifo_level=4. 0x06 is held until a pop frees space. Frames emerge in order 01..06 and frames_sent=6.
- At full, assert in_valid in the same cycle the FSM pops. Required response: no push that cycle and fifo_level goes 4→3. The push lands the following cycle and the level returns to 4.
- Assert reset for 1 cycle mid-DATA of frame 0x3C. Required response: tx_serial=1 immediately, fifo_level=0, frames_sent=0, and no further output until a new push.
- With CIPHER_TX_PARITY_EN defined, send 0xA5 and 0x07. Required response: parity bit is 0 for 0xA5 and 1 for 0x07, and each frame is 44 cycles.
- Preload frames_sent to 0xFFFF via 65535 frames, or force it in simulation, then send one frame. Required response: frames_sent wraps to 0x0000.

Source files
------------

// File: rtl/cipher_uart_tx.sv
// cipher_uart_tx: buffers encrypted bytes from the cipher stage in a small
// FIFO and sends each one as an asynchronous serial frame
// (start, 8 data bits LSB first, optional even parity, stop).
// Optional feature macro: CIPHER_TX_PARITY_EN inserts the parity bit.
module cipher_uart_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    input  logic [7:0]                       in_data,
    output logic                             in_ready,
    output logic                             tx_serial,
    output logic                             tx_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
    output logic [15:0]                      frames_sent
);

    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int TMR_W = $clog2(CLKS_PER_BIT);
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(FIFO_DEPTH);
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef CIPHER_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           state;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;
    logic [TMR_W-1:0] bit_timer;
    logic             bit_done;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
`ifdef CIPHER_TX_PARITY_EN
    logic             parity_bit;
`endif

    // Full means no push, even if the FSM pops in the same cycle.
    assign in_ready = (fifo_level < FULL_LEVEL);
    assign push     = in_valid && in_ready;
    assign pop      = (state == IDLE) && (fifo_level != '0);
    assign bit_done = (bit_timer == TMR_LAST);

    // FIFO storage: written on every accepted push.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_level <= fifo_level + 1'b1;
            end else if (pop && !push) begin
                fifo_level <= fifo_level - 1'b1;
            end
        end
    end

    // Frame sequencer; tx_serial is registered and updated together with the
    // state so each bit appears on the edge that enters it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            tx_serial   <= 1'b1;
            tx_busy     <= 1'b0;
            bit_timer   <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            frames_sent <= '0;
`ifdef CIPHER_TX_PARITY_EN
            parity_bit  <= 1'b0;
`endif
        end else begin
            if (state != IDLE) begin
                bit_timer <= bit_done ? '0 : bit_timer + 1'b1;
            end
            case (state)
                IDLE: begin
                    tx_serial <= 1'b1;
                    if (pop) begin
                        shift      <= mem[rd_ptr];
`ifdef CIPHER_TX_PARITY_EN
                        parity_bit <= ^mem[rd_ptr];
`endif
                        bit_timer  <= '0;
                        bit_idx    <= '0;
                        tx_serial  <= 1'b0;
                        tx_busy    <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        tx_serial <= shift[0];
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        shift <= {1'b0, shift[7:1]};
                        if (bit_idx == 3'd7) begin
`ifdef CIPHER_TX_PARITY_EN
                            tx_serial <= parity_bit;
                            state     <= PARITY;
`else
                            tx_serial <= 1'b1;
                            state     <= STOP;
`endif
                        end else begin
                            bit_idx   <= bit_idx + 1'b1;
                            tx_serial <= shift[1];
                        end
                    end
                end
`ifdef CIPHER_TX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        tx_serial <= 1'b1;
                        state     <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_done) begin
                        tx_serial   <= 1'b1;
                        tx_busy     <= 1'b0;
                        frames_sent <= frames_sent + 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    tx_serial <= 1'b1;
                    tx_busy   <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cipher_uart_tx.sv
// tb_cipher_uart_tx: directed stimulus with a scoreboard; a serial-line
// monitor decodes each frame and checks it against the queued bytes.
module tb_cipher_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef CIPHER_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FL = NBITS * CPB;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        tx_serial;
    logic        tx_busy;
    logic [2:0]  fifo_level;
    logic [15:0] frames_sent;

    int tests;
    int fails;
    logic [7:0] exp_q[$];

    cipher_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .tx_serial(tx_serial),
        .tx_busy(tx_busy),
        .fifo_level(fifo_level),
        .frames_sent(frames_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("push_ready_wait", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_q.push_back(b);
    endtask

    // Serial-line monitor: samples mid-bit on falling edges.
    initial begin
        bit        active;
        int        cyc;
        int        busy_cnt;
        int        b;
        logic [7:0] byte_v;
        logic      start_v;
        logic      stop_v;
        logic      par_v;
        logic [7:0] exp_b;
        active   = 1'b0;
        cyc      = 0;
        busy_cnt = 0;
        byte_v   = '0;
        start_v  = 1'b1;
        stop_v   = 1'b0;
        par_v    = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                active = 1'b0;
            end else if (!active) begin
                if (tx_serial == 1'b0) begin
                    active   = 1'b1;
                    cyc      = 0;
                    busy_cnt = tx_busy ? 1 : 0;
                    byte_v   = '0;
                end
            end else begin
                cyc++;
                if (cyc < FL) begin
                    if (tx_busy) busy_cnt++;
                    if (cyc % CPB == CPB / 2) begin
                        b = cyc / CPB;
                        if (b == 0) start_v = tx_serial;
                        else if (b <= 8) byte_v[b-1] = tx_serial;
                        else if (b == NBITS - 1) stop_v = tx_serial;
                        else par_v = tx_serial;
                    end
                end else begin
                    active = 1'b0;
                    check("frame_start_bit", {31'd0, start_v}, 32'd0);
                    check("frame_stop_bit", {31'd0, stop_v}, 32'd1);
                    check("frame_busy_len", busy_cnt, FL);
                    check("frame_idle_gap", {30'd0, tx_busy, tx_serial}, 32'd1);
                    if (exp_q.size() == 0) begin
                        check("frame_unexpected", {24'd0, byte_v}, 32'hFFFF_FFFF);
                    end else begin
                        exp_b = exp_q.pop_front();
                        check("frame_data", {24'd0, byte_v}, {24'd0, exp_b});
`ifdef CIPHER_TX_PARITY_EN
                        check("frame_parity", {31'd0, par_v}, {31'd0, ^exp_b});
`endif
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef CIPHER_TX_PARITY_EN
        logic [0:10] pat_a5;
`else
        logic [0:9]  pat_a5;
`endif
        logic [7:0] stream [6];
        int errs;
        int cnt;

        tests = 0;
        fails = 0;
`ifdef CIPHER_TX_PARITY_EN
        pat_a5 = 11'b01010010101;
`else
        pat_a5 = 10'b0101001011;
`endif
        stream[0] = 8'h01; stream[1] = 8'h02; stream[2] = 8'h03;
        stream[3] = 8'h04; stream[4] = 8'h05; stream[5] = 8'h06;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx_serial", {31'd0, tx_serial}, 32'd1);
        check("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
        check("rst_fifo_level", {29'd0, fifo_level}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_frames_sent", {16'd0, frames_sent}, 32'd0);
        reset = 1'b0;

        // Single 0xA5 frame: exact bit sequence, latency and busy window.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_q.push_back(8'hA5);
        @(negedge clk);
        check("a5_level_one", {29'd0, fifo_level}, 32'd1);
        check("a5_line_idle", {31'd0, tx_serial}, 32'd1);
        errs = 0;
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            if (i == 0) check("a5_level_zero", {29'd0, fifo_level}, 32'd0);
            if (tx_serial !== pat_a5[i / CPB] || tx_busy !== 1'b1) errs++;
        end
        check("a5_bit_errors", errs, 0);
        @(negedge clk);
        check("a5_busy_end", {31'd0, tx_busy}, 32'd0);
        check("a5_frames_sent", {16'd0, frames_sent}, 32'd1);

        // Back-to-back burst 01..06 from a fresh reset.
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        errs = 0;
        for (int k = 0; k < 5; k++) begin
            in_data = stream[k];
            if (in_ready !== 1'b1) errs++;
            @(posedge clk);
            #1;
            exp_q.push_back(stream[k]);
            @(negedge clk);
        end
        check("burst_ready_high", errs, 0);
        in_data = stream[5];
        check("burst_full_level", {29'd0, fifo_level}, 32'd4);
        check("burst_full_ready", {31'd0, in_ready}, 32'd0);
        cnt = 0;
        while (fifo_level == 3'd4 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("full_pop_delay", cnt, 38);
        check("full_pop_level", {29'd0, fifo_level}, 32'd3);
        check("full_pop_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_q.push_back(stream[5]);
        @(negedge clk);
        check("full_refill_level", {29'd0, fifo_level}, 32'd4);
        cnt = 0;
        while (frames_sent != 16'd6 && cnt < 600) begin
            @(negedge clk);
            cnt++;
        end
        check("burst_frames_sent", {16'd0, frames_sent}, 32'd6);
        @(negedge clk);
        check("burst_queue_drained", exp_q.size(), 0);

        // Reset in the middle of a 0x3C frame with another byte queued.
        push_byte(8'h3C);
        push_byte(8'h55);
        repeat (5) @(negedge clk);
        check("mid_data_bit0", {31'd0, tx_serial}, 32'd0);
        check("mid_level", {29'd0, fifo_level}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_tx_serial", {31'd0, tx_serial}, 32'd1);
        check("mid_rst_busy", {31'd0, tx_busy}, 32'd0);
        check("mid_rst_level", {29'd0, fifo_level}, 32'd0);
        check("mid_rst_frames", {16'd0, frames_sent}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        #2 reset = 1'b0;
        errs = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx_serial !== 1'b1 || tx_busy !== 1'b0) errs++;
        end
        check("post_rst_silent", errs, 0);

        // frames_sent wrap from 0xFFFF.
        @(negedge clk);
        force dut.frames_sent = 16'hFFFF;
        @(negedge clk);
        release dut.frames_sent;
        @(negedge clk);
        check("wrap_preload", {16'd0, frames_sent}, 32'h0000_FFFF);
        push_byte(8'h96);
        cnt = 0;
        while (frames_sent == 16'hFFFF && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check("wrap_frames_sent", {16'd0, frames_sent}, 32'd0);
        @(negedge clk);
        check("final_queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
